// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter (pipeline > MDU/debug round-robin) + MDU RAW scoreboard; RF_WB_STARVE_GUARD_EN adds starvation stall_req.
// Latency: grant decided combinationally, rf_we/rf_waddr/rf_wdata registered one cycle later.
// Backpressure: pipeline never stalled; MDU/debug held off via mdu_ready/dbg_ready.
module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_wdata,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_wdata,
    output logic        mdu_ready,
    input  logic        dbg_valid,
    input  logic [4:0]  dbg_rd,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ready,
    input  logic        mdu_issue,
    input  logic [4:0]  mdu_issue_rd,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        hazard_rs,
    output logic        hazard_rt,
    output logic        issue_block,
    output logic        stall_req,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    logic        rr_ptr;
    logic [31:0] pending;
    logic [31:0] pending_nxt;
    logic        mdu_fire;
    logic        dbg_fire;
    logic        sec_grant;
    logic        win_vld;
    logic [4:0]  win_rd;
    logic [31:0] win_dat;

    // rr_ptr only breaks ties; a lone secondary is always served when pipe_we is low
    always_comb begin
        mdu_ready = 1'b0;
        dbg_ready = 1'b0;
        if (!rst && !pipe_we) begin
            if (mdu_valid && (!dbg_valid || !rr_ptr))
                mdu_ready = 1'b1;
            else if (dbg_valid)
                dbg_ready = 1'b1;
        end
    end

    assign mdu_fire  = mdu_valid && mdu_ready;
    assign dbg_fire  = dbg_valid && dbg_ready;
    assign sec_grant = mdu_fire || dbg_fire;

    always_comb begin
        win_vld = 1'b0;
        win_rd  = 5'd0;
        win_dat = 32'd0;
        if (pipe_we) begin
            win_vld = 1'b1;
            win_rd  = pipe_rd;
            win_dat = pipe_wdata;
        end else if (mdu_fire) begin
            win_vld = 1'b1;
            win_rd  = mdu_rd;
            win_dat = mdu_wdata;
        end else if (dbg_fire) begin
            win_vld = 1'b1;
            win_rd  = dbg_rd;
            win_dat = dbg_wdata;
        end
    end

    // set beats clear when a new issue targets the register being retired
    always_comb begin
        pending_nxt = pending;
        if (mdu_fire)
            pending_nxt[mdu_rd] = 1'b0;
        if (mdu_issue && (mdu_issue_rd != 5'd0))
            pending_nxt[mdu_issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    assign hazard_rs   = pending[rs_addr];
    assign hazard_rt   = pending[rt_addr];
    assign issue_block = pending[mdu_issue_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
            rr_ptr   <= 1'b0;
            pending  <= 32'd0;
        end else begin
            pending <= pending_nxt;
            rf_we   <= win_vld && (win_rd != 5'd0);
            if (win_vld && (win_rd != 5'd0)) begin
                rf_waddr <= win_rd;
                rf_wdata <= win_dat;
            end
            if (sec_grant)
                rr_ptr <= mdu_fire;
        end
    end

`ifdef RF_WB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;
    logic [3:0] starve_nxt;

    always_comb begin
        starve_nxt = starve_cnt;
        if (sec_grant)
            starve_nxt = 4'd0;
        else if ((mdu_valid || dbg_valid) && (starve_cnt < 4'(STARVE_LIMIT)))
            starve_nxt = starve_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
            stall_req  <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            stall_req  <= (starve_nxt == 4'(STARVE_LIMIT));
        end
    end
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: vector table, scoreboard/reset/starvation sequences, randomized run vs reference model.
module tb_rf_wb_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wdata;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_wdata;
    logic        mdu_ready;
    logic        dbg_valid;
    logic [4:0]  dbg_rd;
    logic [31:0] dbg_wdata;
    logic        dbg_ready;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_rd;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        hazard_rs;
    logic        hazard_rt;
    logic        issue_block;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_wdata(mdu_wdata), .mdu_ready(mdu_ready),
        .dbg_valid(dbg_valid), .dbg_rd(dbg_rd), .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready),
        .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .hazard_rs(hazard_rs), .hazard_rt(hazard_rt), .issue_block(issue_block),
        .stall_req(stall_req), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        pw;
        logic [4:0]  prd;
        logic [31:0] pwd;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mwd;
        logic        dv;
        logic [4:0]  drd;
        logic [31:0] dwd;
        logic        e_mr;
        logic        e_dr;
        logic        e_we;
        logic        chk_a;
        logic [4:0]  e_a;
        logic [31:0] e_d;
    } vec_t;

    function automatic vec_t mk(input logic pw, input logic [4:0] prd, input logic [31:0] pwd,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] mwd,
                                input logic dv, input logic [4:0] drd, input logic [31:0] dwd,
                                input logic e_mr, input logic e_dr, input logic e_we,
                                input logic chk_a, input logic [4:0] e_a, input logic [31:0] e_d);
        vec_t v;
        v.pw = pw; v.prd = prd; v.pwd = pwd;
        v.mv = mv; v.mrd = mrd; v.mwd = mwd;
        v.dv = dv; v.drd = drd; v.dwd = dwd;
        v.e_mr = e_mr; v.e_dr = e_dr; v.e_we = e_we;
        v.chk_a = chk_a; v.e_a = e_a; v.e_d = e_d;
        return v;
    endfunction

    task automatic idle_inputs();
        pipe_we = 1'b0; pipe_rd = 5'd0; pipe_wdata = 32'd0;
        mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_wdata = 32'd0;
        dbg_valid = 1'b0; dbg_rd = 5'd0; dbg_wdata = 32'd0;
        mdu_issue = 1'b0; mdu_issue_rd = 5'd0; rs_addr = 5'd0; rt_addr = 5'd0;
    endtask

    // reference model state
    bit          m_pend [32];
    bit          m_we;
    logic [4:0]  m_a;
    logic [31:0] m_d;
    int          m_turn;
    int          m_cnt;
    bit          m_stall;

    vec_t vt[10];

    initial begin
        bit e_mr, e_dr, last_mfire, last_dfire;
        rst = 1'b1;
        idle_inputs();

        vt[0] = mk(1'b1, 5'd5, 32'h1234, 1'b1, 5'd9, 32'h9, 1'b0, 5'd0, 32'h0,
                   1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 32'h1234);
        vt[1] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0,
                   1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'hA0);
        vt[2] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hA1, 1'b1, 5'd11, 32'hB1,
                   1'b0, 1'b1, 1'b1, 1'b1, 5'd11, 32'hB1);
        vt[3] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hA2, 1'b1, 5'd11, 32'hB2,
                   1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'hA2);
        vt[4] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hA3, 1'b1, 5'd11, 32'hB3,
                   1'b0, 1'b1, 1'b1, 1'b1, 5'd11, 32'hB3);
        vt[5] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF,
                   1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        vt[6] = mk(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44,
                   1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h33);
        vt[7] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC0, 1'b0, 5'd0, 32'h0,
                   1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'hC0);
        vt[8] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hC1, 1'b0, 5'd0, 32'h0,
                   1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 32'hC1);
        vt[9] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b1, 5'd13, 32'hC1);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // vector table
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pipe_we = vt[i].pw; pipe_rd = vt[i].prd; pipe_wdata = vt[i].pwd;
            mdu_valid = vt[i].mv; mdu_rd = vt[i].mrd; mdu_wdata = vt[i].mwd;
            dbg_valid = vt[i].dv; dbg_rd = vt[i].drd; dbg_wdata = vt[i].dwd;
            #1;
            chk($sformatf("vec%0d_mdu_ready", i), 32'(mdu_ready), 32'(vt[i].e_mr));
            chk($sformatf("vec%0d_dbg_ready", i), 32'(dbg_ready), 32'(vt[i].e_dr));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_rf_we", i), 32'(rf_we), 32'(vt[i].e_we));
            if (vt[i].chk_a) begin
                chk($sformatf("vec%0d_rf_waddr", i), 32'(rf_waddr), 32'(vt[i].e_a));
                chk($sformatf("vec%0d_rf_wdata", i), rf_wdata, vt[i].e_d);
            end
        end
        @(negedge clk);
        idle_inputs();

`ifdef RF_WB_STARVE_GUARD_EN
        // starvation: pipeline holds the port while MDU waits
        for (int k = 1; k <= LIMIT + 1; k++) begin
            @(negedge clk);
            pipe_we = 1'b1; pipe_rd = 5'd1; pipe_wdata = 32'h11;
            mdu_valid = 1'b1; mdu_rd = 5'd14; mdu_wdata = 32'hE0;
            #1;
            chk($sformatf("starve%0d_mdu_ready", k), 32'(mdu_ready), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("starve%0d_stall", k), 32'(stall_req), 32'(k >= LIMIT));
        end
        @(negedge clk);
        pipe_we = 1'b0;
        #1;
        chk("starve_grant_mdu_ready", 32'(mdu_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("starve_release_stall", 32'(stall_req), 32'd0);
        chk("starve_release_waddr", 32'(rf_waddr), 32'd14);
        @(negedge clk);
        idle_inputs();
`endif

        // scoreboard sequence
        @(negedge clk);
        mdu_issue = 1'b1; mdu_issue_rd = 5'd7;
        #1;
        chk("sb_issue_block_clear", 32'(issue_block), 32'd0);
        @(negedge clk);
        mdu_issue = 1'b0; rs_addr = 5'd7; rt_addr = 5'd8;
        #1;
        chk("sb_hazard_rs_set", 32'(hazard_rs), 32'd1);
        chk("sb_hazard_rt_other", 32'(hazard_rt), 32'd0);
        chk("sb_issue_block_waw", 32'(issue_block), 32'd1);
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_wdata = 32'h77;
        #1;
        chk("sb_accept_ready", 32'(mdu_ready), 32'd1);
        chk("sb_hazard_before_update", 32'(hazard_rs), 32'd1);
        @(negedge clk);
        mdu_valid = 1'b0; mdu_issue = 1'b1; mdu_issue_rd = 5'd7;
        #1;
        chk("sb_hazard_rs_cleared", 32'(hazard_rs), 32'd0);
        @(negedge clk);
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_wdata = 32'h78;
        #1;
        chk("sb_accept2_ready", 32'(mdu_ready), 32'd1);
        @(negedge clk);
        mdu_valid = 1'b0; mdu_issue = 1'b0;
        #1;
        chk("sb_set_wins", 32'(hazard_rs), 32'd1);

        // reset mid-handshake with pending[3] set and a nonzero write
        @(negedge clk);
        mdu_issue = 1'b1; mdu_issue_rd = 5'd3; pipe_we = 1'b1; pipe_rd = 5'd9; pipe_wdata = 32'h99;
        @(negedge clk);
        idle_inputs();
        rs_addr = 5'd3;
        #1;
        chk("prerst_pending3", 32'(hazard_rs), 32'd1);
        chk("prerst_waddr", 32'(rf_waddr), 32'd9);
        rst = 1'b1; mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_wdata = 32'h3;
        #1;
        chk("rst_mdu_ready", 32'(mdu_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0; mdu_valid = 1'b0;
        #1;
        chk("rst2_rf_we", 32'(rf_we), 32'd0);
        chk("rst2_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst2_rf_wdata", rf_wdata, 32'd0);
        chk("rst2_pending3", 32'(hazard_rs), 32'd0);
        chk("rst2_stall", 32'(stall_req), 32'd0);

        // randomized run against the reference model
        foreach (m_pend[j]) m_pend[j] = 1'b0;
        m_we = 1'b0; m_a = 5'd0; m_d = 32'd0; m_turn = 0; m_cnt = 0; m_stall = 1'b0;
        last_mfire = 1'b0; last_dfire = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            pipe_we = ($urandom_range(0, 2) == 0);
            pipe_rd = 5'($urandom_range(0, 7));
            pipe_wdata = $urandom;
            if (!mdu_valid || last_mfire) begin
                mdu_valid = ($urandom_range(0, 1) == 1);
                mdu_rd = 5'($urandom_range(0, 7));
                mdu_wdata = $urandom;
            end
            if (!dbg_valid || last_dfire) begin
                dbg_valid = ($urandom_range(0, 2) == 0);
                dbg_rd = 5'($urandom_range(0, 7));
                dbg_wdata = $urandom;
            end
            mdu_issue = ($urandom_range(0, 2) == 0);
            mdu_issue_rd = 5'($urandom_range(0, 7));
            rs_addr = 5'($urandom_range(0, 7));
            rt_addr = 5'($urandom_range(0, 7));
            #1;
            e_mr = 1'b0; e_dr = 1'b0;
            if (!pipe_we) begin
                if (mdu_valid && dbg_valid) begin
                    if (m_turn == 0) e_mr = 1'b1; else e_dr = 1'b1;
                end else begin
                    e_mr = mdu_valid;
                    e_dr = dbg_valid;
                end
            end
            chk("rnd_mdu_ready", 32'(mdu_ready), 32'(e_mr));
            chk("rnd_dbg_ready", 32'(dbg_ready), 32'(e_dr));
            chk("rnd_hazard_rs", 32'(hazard_rs), 32'(m_pend[rs_addr]));
            chk("rnd_hazard_rt", 32'(hazard_rt), 32'(m_pend[rt_addr]));
            chk("rnd_issue_block", 32'(issue_block), 32'(m_pend[mdu_issue_rd]));
            chk("rnd_rf_we", 32'(rf_we), 32'(m_we));
            chk("rnd_rf_waddr", 32'(rf_waddr), 32'(m_a));
            chk("rnd_rf_wdata", rf_wdata, m_d);
            chk("rnd_stall", 32'(stall_req), 32'(m_stall));
            @(posedge clk);
            m_we = 1'b0;
            if (pipe_we && pipe_rd != 5'd0) begin
                m_we = 1'b1; m_a = pipe_rd; m_d = pipe_wdata;
            end else if (e_mr && mdu_rd != 5'd0) begin
                m_we = 1'b1; m_a = mdu_rd; m_d = mdu_wdata;
            end else if (e_dr && dbg_rd != 5'd0) begin
                m_we = 1'b1; m_a = dbg_rd; m_d = dbg_wdata;
            end
            if (e_mr) m_turn = 1;
            if (e_dr) m_turn = 0;
            if (e_mr) m_pend[mdu_rd] = 1'b0;
            if (mdu_issue && mdu_issue_rd != 5'd0) m_pend[mdu_issue_rd] = 1'b1;
`ifdef RF_WB_STARVE_GUARD_EN
            if (e_mr || e_dr) m_cnt = 0;
            else if ((mdu_valid || dbg_valid) && m_cnt < LIMIT) m_cnt = m_cnt + 1;
            m_stall = (m_cnt == LIMIT);
`endif
            last_mfire = e_mr;
            last_dfire = e_dr;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
